// File: rtl/mbist_data_cmp.sv
// mbist_data_cmp: read-side compare engine for memory BIST.
// Delays the expected pattern word and address by the memory read latency.
// Compares them against the returned read data, and records the first-fail
// address/mask plus a saturating fail count. The result registers double as
// a serial scan chain, {err_sticky, err_cnt, err_addr, err_mask}, which
// shifts out LSB first on sdo.
module mbist_data_cmp #(
  parameter int BIST_DATA_WD    = 32,
  parameter int BIST_ADDR_WD    = 10,
  parameter int BIST_ERR_CNT_WD = 8,
  parameter int RD_LATENCY      = 1    // legal range 1..4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       clr,
  input  logic                       cmp_en,
  input  logic                       cmp_inv,
  input  logic [BIST_DATA_WD-1:0]    pat_data,
  input  logic [BIST_ADDR_WD-1:0]    cmp_addr,
  input  logic [BIST_DATA_WD-1:0]    mem_rdata,
  input  logic                       scan_shift,
  input  logic                       sdi,
  output logic                       sdo,
  output logic                       cmp_err,
  output logic                       err_sticky,
  output logic [BIST_ADDR_WD-1:0]    err_addr,
  output logic [BIST_DATA_WD-1:0]    err_mask,
  output logic [BIST_ERR_CNT_WD-1:0] err_cnt
);

  // Pipeline stage 0 holds the most recent issue; stage RD_LATENCY-1 is the
  // tail, which lines up with mem_rdata.
  logic [RD_LATENCY-1:0]   r_pipe_vld;
  logic [BIST_DATA_WD-1:0] r_pipe_exp  [RD_LATENCY];
  logic [BIST_ADDR_WD-1:0] r_pipe_addr [RD_LATENCY];

  logic                       r_cmp_err;
  logic                       r_err_sticky;
  logic [BIST_ERR_CNT_WD-1:0] r_err_cnt;
  logic [BIST_ADDR_WD-1:0]    r_err_addr;
  logic [BIST_DATA_WD-1:0]    r_err_mask;

  logic                    w_issue;
  logic                    w_flush;
  logic [BIST_DATA_WD-1:0] w_exp_word;
  logic                    w_tail_vld;
  logic [BIST_DATA_WD-1:0] w_mask;
  logic                    w_fail;
  logic                    w_cnt_sat;

  // A compare is only issued while the engine runs and the chain is idle.
  assign w_issue    = cmp_en & run & ~scan_shift;
  assign w_flush    = ~run | clr;
  assign w_exp_word = pat_data ^ {BIST_DATA_WD{cmp_inv}};

  // The tail is compared only if this cycle is not itself flushing or
  // shifting, so a dropped read can never leave a trace in the results.
  assign w_tail_vld = r_pipe_vld[RD_LATENCY-1];
  assign w_mask     = r_pipe_exp[RD_LATENCY-1] ^ mem_rdata;
  assign w_fail     = w_tail_vld & run & ~clr & ~scan_shift & (|w_mask);
  assign w_cnt_sat  = &r_err_cnt;

  // Valid bits: shift one stage per cycle, cleared by reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
    end else if (w_flush) begin
      r_pipe_vld <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, so the loop order does not matter.
      r_pipe_vld[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
    end
  end

  // Expected word/address: plain shift register that advances every cycle.
  // NOTE: no reset here on purpose; the payload is qualified by its valid
  // bit, so resetting it would only add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    r_pipe_exp[0]  <= w_exp_word;
    r_pipe_addr[0] <= cmp_addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_pipe_exp[i]  <= r_pipe_exp[i-1];
      r_pipe_addr[i] <= r_pipe_addr[i-1];
    end
  end

  // Result registers: clr beats scan, and scan beats compare updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_err_addr   <= '0;
      r_err_mask   <= '0;
    end else if (clr) begin
      r_cmp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_err_addr   <= '0;
      r_err_mask   <= '0;
    end else if (scan_shift) begin
      r_cmp_err <= 1'b0;
      {r_err_sticky, r_err_cnt, r_err_addr, r_err_mask} <=
        {sdi, r_err_sticky, r_err_cnt, r_err_addr, r_err_mask[BIST_DATA_WD-1:1]};
    end else begin
      r_cmp_err <= w_fail;
      if (w_fail) begin
        if (!w_cnt_sat) begin
          r_err_cnt <= r_err_cnt + BIST_ERR_CNT_WD'(1);
        end
        // Only the first fail since reset/clr is captured in detail.
        if (!r_err_sticky) begin
          r_err_sticky <= 1'b1;
          r_err_addr   <= r_pipe_addr[RD_LATENCY-1];
          r_err_mask   <= w_mask;
        end
      end
    end
  end

  assign sdo        = r_err_mask[0];
  assign cmp_err    = r_cmp_err;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign err_addr   = r_err_addr;
  assign err_mask   = r_err_mask;

endmodule

// File: tb/tb_mbist_data_cmp.sv
// Bench for mbist_data_cmp: two instances (read latency 1 and 2) share all
// inputs except read data. A transaction-level model keeps the outstanding
// reads in a queue, each tagged with the cycle its data is due.
module tb_mbist_data_cmp;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int CW  = 8;
  localparam int LEN = 1 + CW + AW + DW;
  localparam int OW  = LEN + 2;

  typedef struct packed {
    logic [DW-1:0] exp;
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          clr = 1'b0;
  logic          cmp_en = 1'b0;
  logic          cmp_inv = 1'b0;
  logic          scan_shift = 1'b0;
  logic          sdi = 1'b0;
  logic [DW-1:0] pat_data = '0;
  logic [AW-1:0] cmp_addr = '0;
  logic [DW-1:0] rdata0 = '0;
  logic [DW-1:0] rdata1 = '0;

  logic          sdo0, cmp_err0, sticky0, sdo1, cmp_err1, sticky1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] mask0, mask1;
  logic [CW-1:0] cnt0, cnt1;
  logic [OW-1:0] obs [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  int            lat [2] = '{1, 2};
  pend_t         pq [2][$];
  logic          m_cmp_err [2];
  logic          m_sticky  [2];
  logic [CW-1:0] m_cnt     [2];
  logic [AW-1:0] m_addr    [2];
  logic [DW-1:0] m_mask    [2];

  always #5 clk = ~clk;

  mbist_data_cmp #(.RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .cmp_en(cmp_en),
    .cmp_inv(cmp_inv), .pat_data(pat_data), .cmp_addr(cmp_addr),
    .mem_rdata(rdata0), .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo0),
    .cmp_err(cmp_err0), .err_sticky(sticky0), .err_addr(addr0),
    .err_mask(mask0), .err_cnt(cnt0)
  );

  mbist_data_cmp #(.RD_LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .cmp_en(cmp_en),
    .cmp_inv(cmp_inv), .pat_data(pat_data), .cmp_addr(cmp_addr),
    .mem_rdata(rdata1), .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo1),
    .cmp_err(cmp_err1), .err_sticky(sticky1), .err_addr(addr1),
    .err_mask(mask1), .err_cnt(cnt1)
  );

  assign obs[0] = {sdo0, cmp_err0, sticky0, cnt0, addr0, mask0};
  assign obs[1] = {sdo1, cmp_err1, sticky1, cnt1, addr1, mask1};

  function automatic logic [OW-1:0] exp_vec(input int d);
    return {m_mask[d][0], m_cmp_err[d], m_sticky[d], m_cnt[d], m_addr[d], m_mask[d]};
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      pq[d].delete();
      m_cmp_err[d] = 1'b0;
      m_sticky[d]  = 1'b0;
      m_cnt[d]     = '0;
      m_addr[d]    = '0;
      m_mask[d]    = '0;
    end
  endtask

  // Model of one clock edge for instance d, given the read data it sees.
  task automatic model_edge(input int d, input logic [DW-1:0] rd);
    logic          hit;
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    logic [LEN-1:0] ch;
    pend_t         p;
    hit = 1'b0;
    e   = '0;
    a   = '0;
    if (pq[d].size() != 0 && pq[d][0].due == cyc) begin
      p   = pq[d].pop_front();
      hit = run && !clr && !scan_shift;
      e   = p.exp;
      a   = p.addr;
    end
    if (!run || clr) pq[d].delete();
    if (cmp_en && run && !scan_shift && !clr) begin
      p.exp  = pat_data ^ {DW{cmp_inv}};
      p.addr = cmp_addr;
      p.due  = cyc + lat[d];
      pq[d].push_back(p);
    end
    m_cmp_err[d] = 1'b0;
    if (clr) begin
      m_sticky[d] = 1'b0;
      m_cnt[d]    = '0;
      m_addr[d]   = '0;
      m_mask[d]   = '0;
    end else if (scan_shift) begin
      ch = {m_sticky[d], m_cnt[d], m_addr[d], m_mask[d]};
      ch = {sdi, ch[LEN-1:1]};
      {m_sticky[d], m_cnt[d], m_addr[d], m_mask[d]} = ch;
    end else if (hit && ((e ^ rd) != '0)) begin
      m_cmp_err[d] = 1'b1;
      if (m_cnt[d] != 8'hFF) m_cnt[d] = m_cnt[d] + 8'd1;
      if (!m_sticky[d]) begin
        m_sticky[d] = 1'b1;
        m_addr[d]   = a;
        m_mask[d]   = e ^ rd;
      end
    end
  endtask

  // One clock: read data for a due read is its expected word XOR flip.
  task automatic step(input logic [DW-1:0] flip);
    logic [DW-1:0] rd [2];
    for (int d = 0; d < 2; d++) begin
      rd[d] = $urandom;
      if (pq[d].size() != 0 && pq[d][0].due == cyc) rd[d] = pq[d][0].exp ^ flip;
    end
    rdata0 = rd[0];
    rdata1 = rd[1];
    model_edge(0, rd[0]);
    model_edge(1, rd[1]);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d got=%h exp=0", d, obs[d]);
      end
    end
    rst = 1'b0;
    run = 1'b1;
  endtask

  task automatic test_match();
    cmp_en = 1'b1; cmp_inv = 1'b0; pat_data = 32'hA5A5A5A5; cmp_addr = 10'h010;
    for (int c = 0; c < 4; c++) begin
      step('0);
      cmp_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL match c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if ({cmp_err0, sticky0, cnt0} !== 10'd0) begin
      errors++;
      $display("FAIL match_const got=%b/%b/%h exp=0/0/00", cmp_err0, sticky0, cnt0);
    end
  endtask

  task automatic test_first_fail();
    cmp_en = 1'b1; cmp_inv = 1'b1; pat_data = 32'hA5A5A5A5; cmp_addr = 10'h010;
    for (int c = 0; c < 4; c++) begin
      step(32'h1);
      cmp_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL first_fail c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
      if (c == 1) begin
        checks++;
        if ({cmp_err0, sticky0, addr0, mask0, cnt0} !== {1'b1, 1'b1, 10'h010, 32'h1, 8'd1}) begin
          errors++;
          $display("FAIL first_fail_const got err=%b st=%b addr=%h mask=%h cnt=%h exp 1 1 010 00000001 01",
                   cmp_err0, sticky0, addr0, mask0, cnt0);
        end
      end
      if (c == 2) begin
        checks++;
        if (cmp_err0 !== 1'b0) begin
          errors++;
          $display("FAIL first_fail_pulse got=%b exp=0", cmp_err0);
        end
      end
    end
  endtask

  task automatic test_hold_first();
    cmp_en = 1'b1; cmp_inv = 1'b0; pat_data = $urandom; cmp_addr = 10'h011;
    for (int c = 0; c < 4; c++) begin
      step(32'h8000_0000);
      cmp_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL hold_first c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if ({addr0, mask0, cnt0} !== {10'h010, 32'h1, 8'd2}) begin
      errors++;
      $display("FAIL hold_first_const got addr=%h mask=%h cnt=%h exp 010 00000001 02", addr0, mask0, cnt0);
    end
  endtask

  // Back-to-back failing reads every cycle; counter must saturate.
  task automatic test_back_to_back();
    for (int c = 0; c < 303; c++) begin
      cmp_en   = (c < 300);
      cmp_inv  = 1'($urandom);
      pat_data = $urandom;
      cmp_addr = AW'($urandom);
      step($urandom | 32'h1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL b2b c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if ({cnt0, cnt1} !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_saturate got=%h/%h exp=ff/ff", cnt0, cnt1);
    end
  endtask

  task automatic test_flush();
    logic any_err;
    clr = 1'b1;
    step('0);
    clr = 1'b0;
    // run dropped the cycle after issue
    any_err = 1'b0;
    cmp_en = 1'b1; cmp_inv = 1'b0; pat_data = $urandom; cmp_addr = 10'h155;
    for (int c = 0; c < 4; c++) begin
      run = (c != 1);
      step(32'h0000_0F00);
      cmp_en = 1'b0;
      any_err = any_err | cmp_err0 | cmp_err1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL flush_run c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if ({any_err, cnt0, cnt1} !== 17'd0) begin
      errors++;
      $display("FAIL flush_run_const got err=%b cnt=%h/%h exp 0 00/00", any_err, cnt0, cnt1);
    end
    // clr asserted the cycle after issue, with earlier results present
    cmp_en = 1'b1; pat_data = $urandom; cmp_addr = 10'h2AA;
    step('0);
    step(32'h1);
    step(32'h1);
    cmp_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      clr = (c == 1);
      step(32'h0000_0F00);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL flush_clr c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== '0) begin
        errors++;
        $display("FAIL flush_clr_const dut%0d got=%h exp=0", d, obs[d]);
      end
    end
  endtask

  task automatic test_scan();
    logic [LEN-1:0] bits;
    logic [LEN-1:0] want;
    cmp_en = 1'b1; cmp_inv = 1'b1; pat_data = 32'hA5A5A5A5; cmp_addr = 10'h010;
    step(32'h1);
    cmp_en = 1'b0;
    repeat (3) step(32'h1);
    scan_shift = 1'b1;
    sdi = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      bits[i] = sdo0;
      step($urandom);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL scan i%0d dut%0d got=%h exp=%h", i, d, obs[d], exp_vec(d));
        end
      end
    end
    scan_shift = 1'b0;
    want = {1'b1, 8'd1, 10'h010, 32'h1};
    checks++;
    if (bits !== want) begin
      errors++;
      $display("FAIL scan_stream got=%h exp=%h", bits, want);
    end
    checks++;
    if (obs[0] !== '0) begin
      errors++;
      $display("FAIL scan_empty got=%h exp=0", obs[0]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] flip;
    for (int c = 0; c < 500; c++) begin
      run        = ($urandom % 16) != 0;
      clr        = ($urandom % 64) == 0;
      scan_shift = ($urandom % 32) == 0;
      sdi        = 1'($urandom);
      cmp_en     = ($urandom % 4) != 0;
      cmp_inv    = 1'($urandom);
      pat_data   = $urandom;
      cmp_addr   = AW'($urandom);
      case ($urandom % 4)
        0:       flip = '0;
        1:       flip = 32'(1) << ($urandom % 32);
        default: flip = $urandom;
      endcase
      step(flip);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL random c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    run = 1'b1; clr = 1'b0; scan_shift = 1'b0; cmp_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic any_err;
    clr = 1'b1;
    step('0);
    clr = 1'b0;
    cmp_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      cmp_en   = (c < 5);
      pat_data = $urandom;
      cmp_addr = AW'($urandom);
      step(32'h1);
    end
    checks++;
    if ({cnt0, cnt1} !== {8'd5, 8'd5}) begin
      errors++;
      $display("FAIL pre_reset_cnt got=%h/%h exp=05/05", cnt0, cnt1);
    end
    cmp_en = 1'b1; pat_data = $urandom; cmp_addr = 10'h3C3;
    step('0);
    cmp_en = 1'b0;
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== '0) begin
        errors++;
        $display("FAIL async_reset dut%0d got=%h exp=0", d, obs[d]);
      end
    end
    #1;
    rst = 1'b0;
    any_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(32'hFFFF_FFFF);
      any_err = any_err | cmp_err0 | cmp_err1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL post_reset c%0d dut%0d got=%h exp=%h", c, d, obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if (any_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_no_err got=%b exp=0", any_err);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_first_fail();
    test_hold_first();
    test_back_to_back();
    test_flush();
    test_scan();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
